// File: rtl/ebpf_mem_pkg.sv
// Shared types and helpers for the eBPF data-memory responder.
// Access sizes, exception codes and the responder FSM states live here.
package ebpf_mem_pkg;

   typedef enum logic [1:0] {
      SZ_B  = 2'b00,
      SZ_H  = 2'b01,
      SZ_W  = 2'b10,
      SZ_DW = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      EXC_NONE     = 2'd0,
      EXC_MISALIGN = 2'd1,
      EXC_RANGE    = 2'd2,
      EXC_ILLEGAL  = 2'd3
   } mem_exc_e;

   typedef enum logic {
      ST_SCRUB = 1'b0,
      ST_READY = 1'b1
   } resp_state_e;

   function automatic logic [3:0] size_bytes(input size_e s);
      logic [3:0] n;
      case (s)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Byte-enable pattern for an access of size s starting at byte lane 'lane'.
   function automatic logic [7:0] lane_mask(input size_e s, input logic [2:0] lane);
      logic [7:0] m;
      case (s)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << lane;
   endfunction

endpackage

// File: rtl/ebpf_bytelane_ram.sv
// DEPTH_WORDS x 64 storage with a byte-enabled write port and a registered
// read port. Reads return the pre-edge contents when read and write collide.
module ebpf_bytelane_ram #(
   parameter int DEPTH_WORDS = 512,
   parameter int ADDR_W      = 9
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [7:0]        i_be,
   input  logic [63:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [63:0]       o_rdata
);

   logic [63:0] r_mem [DEPTH_WORDS];
   logic [63:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int i = 0; i < 8; i++) begin
            if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/ebpf_data_mem_responder.sv
// Responder for the eBPF core data-memory interface: byte-addressable
// little-endian RAM with host preload port and a post-reset scrub engine.
module ebpf_data_mem_responder
   import ebpf_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 512,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int          ADDR_W      = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [1:0]        sizeSelect,
   input  logic [63:0]       address,
   input  logic [63:0]       writeData,
   output logic [63:0]       readData,
   output logic [1:0]        dataMemoryExc,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [63:0]       host_wdata,
   output logic              busy
);

   resp_state_e       r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_scrub_ptr, w_scrub_ptr_nxt;

   size_e             w_size;
   logic [63:0]       w_offset;
   logic [ADDR_W-1:0] w_word;
   logic [2:0]        w_lane;
   logic [2:0]        w_size_m1;
   logic              w_req, w_in_range, w_aligned;
   mem_exc_e          w_exc;
   logic              w_st_ok, w_ld_ok, w_host_ok;

   logic [7:0]        w_core_be;
   logic [63:0]       w_core_wd;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [7:0]        w_ram_be;
   logic [63:0]       w_ram_wdata;
   logic [63:0]       w_ram_q;

   mem_exc_e          r_exc_p0;
   logic              r_ld_vld_p0;
   logic [2:0]        r_ld_lane_p0;
   size_e             r_ld_size_p0;
   logic [63:0]       w_ld_shift, w_ld_data;
   logic [63:0]       r_rdata;

   assign w_size     = size_e'(sizeSelect);
   assign w_offset   = address - BASE_ADDR;
   assign w_word     = w_offset[ADDR_W+2:3];
   assign w_lane     = w_offset[2:0];
   assign w_req      = memRead | memWrite;
   // Addresses below BASE_ADDR wrap to huge offsets and land here too.
   assign w_in_range = (w_offset[63:ADDR_W+3] == '0);
   assign w_size_m1  = 3'(size_bytes(w_size) - 4'd1);
   assign w_aligned  = ((w_offset[2:0] & w_size_m1) == 3'b000);

   always_comb begin
      w_exc = EXC_NONE;
      if (w_req) begin
         if ((memRead && memWrite) || (r_state == ST_SCRUB)) w_exc = EXC_ILLEGAL;
         else if (!w_in_range)                                w_exc = EXC_RANGE;
         else if (!w_aligned)                                 w_exc = EXC_MISALIGN;
      end
   end

   assign w_st_ok   = memWrite && (w_exc == EXC_NONE);
   assign w_ld_ok   = memRead  && (w_exc == EXC_NONE);
   assign w_host_ok = host_we  && (r_state == ST_READY);
   assign w_core_be = lane_mask(w_size, w_lane);
   assign w_core_wd = writeData << {w_lane, 3'b000};

   // Single write port: scrub, then core store, then host. A host write to a
   // different word on the same edge as a core store is dropped.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_waddr = host_addr;
      w_ram_be    = 8'h00;
      w_ram_wdata = host_wdata;
      if (r_state == ST_SCRUB) begin
         w_ram_we    = 1'b1;
         w_ram_waddr = r_scrub_ptr;
         w_ram_be    = 8'hFF;
         w_ram_wdata = '0;
      end else if (w_st_ok) begin
         w_ram_we    = 1'b1;
         w_ram_waddr = w_word;
         w_ram_be    = w_core_be;
         w_ram_wdata = w_core_wd;
         if (w_host_ok && (host_addr == w_word)) begin
            w_ram_be = 8'hFF;
            for (int i = 0; i < 8; i++) begin
               w_ram_wdata[8*i +: 8] = w_core_be[i] ? w_core_wd[8*i +: 8]
                                                    : host_wdata[8*i +: 8];
            end
         end
      end else if (w_host_ok) begin
         w_ram_we = 1'b1;
         w_ram_be = 8'hFF;
      end
   end

   ebpf_bytelane_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk    (clk),
      .i_we   (w_ram_we),
      .i_waddr(w_ram_waddr),
      .i_be   (w_ram_be),
      .i_wdata(w_ram_wdata),
      .i_raddr(w_word),
      .o_rdata(w_ram_q)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_scrub_ptr_nxt = r_scrub_ptr;
      case (r_state)
         ST_SCRUB: begin
            w_scrub_ptr_nxt = r_scrub_ptr + ADDR_W'(1);
            if (r_scrub_ptr == ADDR_W'(DEPTH_WORDS - 1)) w_state_nxt = ST_READY;
         end
         ST_READY: w_state_nxt = ST_READY;
         default:  w_state_nxt = ST_SCRUB;
      endcase
   end

   // Stage p0: request edge, RAM word fetched and exception registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_SCRUB;
         r_scrub_ptr <= '0;
         r_exc_p0    <= EXC_NONE;
         r_ld_vld_p0 <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_scrub_ptr <= w_scrub_ptr_nxt;
         r_exc_p0    <= w_exc;
         r_ld_vld_p0 <= w_ld_ok;
      end
   end

   always_ff @(posedge clk) begin
      r_ld_lane_p0 <= w_lane;
      r_ld_size_p0 <= w_size;
   end

   always_comb begin
      w_ld_shift = w_ram_q >> {r_ld_lane_p0, 3'b000};
      w_ld_data  = '0;
      case (r_ld_size_p0)
         SZ_B:    w_ld_data[7:0]  = w_ld_shift[7:0];
         SZ_H:    w_ld_data[15:0] = w_ld_shift[15:0];
         SZ_W:    w_ld_data[31:0] = w_ld_shift[31:0];
         default: w_ld_data       = w_ld_shift;
      endcase
   end

   // Stage p1: lane-extracted load data lands in readData.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
      end else if (r_ld_vld_p0) begin
         r_rdata <= w_ld_data;
      end
   end

   assign readData      = r_rdata;
   assign dataMemoryExc = r_exc_p0;
   assign busy          = (r_state == ST_SCRUB);

endmodule

// File: tb/tb_ebpf_data_mem_responder.sv
// Directed bench for ebpf_data_mem_responder: scrub timing, host preload,
// loads/stores, fault decode and same-edge host/core contention.
module tb_ebpf_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead, memWrite;
   logic [1:0]  sizeSelect;
   logic [63:0] address, writeData;
   logic [63:0] readData;
   logic [1:0]  dataMemoryExc;
   logic        host_we;
   logic [8:0]  host_addr;
   logic [63:0] host_wdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   ebpf_data_mem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .sizeSelect   (sizeSelect),
      .address      (address),
      .writeData    (writeData),
      .readData     (readData),
      .dataMemoryExc(dataMemoryExc),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One request edge, then one idle edge; returns exc after the request edge
   // and readData after the idle edge.
   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] wd,
                      output logic [1:0] exc, output logic [63:0] rdv);
      memRead = rd; memWrite = wr; sizeSelect = sz; address = a; writeData = wd;
      cyc();
      exc = dataMemoryExc;
      memRead = 1'b0; memWrite = 1'b0;
      cyc();
      rdv = readData;
   endtask

   task automatic host_write(input logic [8:0] a, input logic [63:0] d);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      cyc();
      host_we = 1'b0;
   endtask

   // Counts edges from release until busy falls, issuing one load at edge 11.
   task automatic measure_scrub(input string tag, input logic probe);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         if (probe && n == 10) begin
            memRead = 1'b1; sizeSelect = 2'b11; address = 64'h0;
         end
         cyc();
         n++;
         if (probe && n == 11) begin
            memRead = 1'b0;
            n_tests++;
            if (dataMemoryExc !== 2'b11) begin
               n_fail++;
               $display("FAIL busy_load_exc: got %b expected 11", dataMemoryExc);
            end
            n_tests++;
            if (readData !== 64'h0) begin
               n_fail++;
               $display("FAIL busy_load_rdata: got %h expected 0", readData);
            end
         end
      end
      n_tests++;
      if (n != 512) begin
         n_fail++;
         $display("FAIL %s: busy lasted %0d cycles, expected 512", tag, n);
      end
   endtask

   task automatic test_reset();
      logic [1:0]  e;
      logic [63:0] r;
      reset = 1'b0; memRead = 1'b0; memWrite = 1'b0; sizeSelect = 2'b00;
      address = '0; writeData = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      repeat (3) cyc();
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
      n_tests++;
      if (readData !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", readData); end
      n_tests++;
      if (dataMemoryExc !== 2'b00) begin n_fail++; $display("FAIL reset_exc: got %b expected 00", dataMemoryExc); end
      reset = 1'b1;
      measure_scrub("scrub_len", 1'b1);
      req(1'b1, 1'b0, 2'b11, 64'h0, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b00 || r !== 64'h0) begin
         n_fail++;
         $display("FAIL ready_load0: got exc %b data %h expected 00 / 0", e, r);
      end
   endtask

   task automatic test_host_load();
      logic [1:0]  e;
      logic [63:0] r;
      host_write(9'd1, 64'h8877665544332211);
      req(1'b1, 1'b0, 2'b00, 64'h0B, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b00 || r !== 64'h44) begin
         n_fail++; $display("FAIL load_byte_0B: got exc %b data %h expected 00 / 44", e, r);
      end
      n_tests++;
      if (dataMemoryExc !== 2'b00) begin
         n_fail++; $display("FAIL exc_clears: got %b expected 00", dataMemoryExc);
      end
      req(1'b1, 1'b0, 2'b01, 64'h0A, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b00 || r !== 64'h4433) begin
         n_fail++; $display("FAIL load_half_0A: got exc %b data %h expected 00 / 4433", e, r);
      end
      req(1'b1, 1'b0, 2'b10, 64'h0C, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b00 || r !== 64'h88776655) begin
         n_fail++; $display("FAIL load_word_0C: got exc %b data %h expected 00 / 88776655", e, r);
      end
   endtask

   task automatic test_back_to_back();
      memWrite = 1'b1; sizeSelect = 2'b10; address = 64'h10; writeData = 64'h12345678DEADBEEF;
      cyc();
      n_tests++;
      if (dataMemoryExc !== 2'b00) begin n_fail++; $display("FAIL store_w_exc: got %b expected 00", dataMemoryExc); end
      memWrite = 1'b0; memRead = 1'b1; sizeSelect = 2'b11; address = 64'h10;
      cyc();
      memRead = 1'b0;
      cyc();
      n_tests++;
      if (readData !== 64'h00000000DEADBEEF) begin
         n_fail++; $display("FAIL raw_word: got %h expected 00000000deadbeef", readData);
      end
      memWrite = 1'b1; sizeSelect = 2'b01; address = 64'h12; writeData = 64'h000000000000CAFE;
      cyc();
      memWrite = 1'b0; memRead = 1'b1; sizeSelect = 2'b11; address = 64'h10;
      cyc();
      memRead = 1'b0;
      cyc();
      n_tests++;
      if (readData !== 64'h00000000CAFEBEEF) begin
         n_fail++; $display("FAIL raw_half: got %h expected 00000000cafebeef", readData);
      end
   endtask

   task automatic test_faults();
      logic [1:0]  e;
      logic [63:0] r;
      req(1'b1, 1'b0, 2'b01, 64'h03, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b01 || r !== 64'h00000000CAFEBEEF) begin
         n_fail++; $display("FAIL misalign_load: got exc %b data %h expected 01 / cafebeef", e, r);
      end
      req(1'b0, 1'b1, 2'b11, 64'h1004, 64'hFFFFFFFFFFFFFFFF, e, r);
      n_tests++;
      if (e !== 2'b10) begin n_fail++; $display("FAIL range_store: got exc %b expected 10", e); end
      req(1'b1, 1'b0, 2'b11, 64'h0, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b00 || r !== 64'h0) begin
         n_fail++; $display("FAIL range_ram_kept: got exc %b data %h expected 00 / 0", e, r);
      end
      req(1'b1, 1'b1, 2'b11, 64'h08, 64'h0, e, r);
      n_tests++;
      if (e !== 2'b11 || r !== 64'h0) begin
         n_fail++; $display("FAIL rd_wr_both: got exc %b data %h expected 11 / 0", e, r);
      end
      req(1'b0, 1'b1, 2'b01, 64'h09, 64'hFFFF, e, r);
      n_tests++;
      if (e !== 2'b01) begin n_fail++; $display("FAIL misalign_store: got exc %b expected 01", e); end
      req(1'b1, 1'b0, 2'b11, 64'h08, 64'h0, e, r);
      n_tests++;
      if (r !== 64'h8877665544332211) begin
         n_fail++; $display("FAIL fault_ram_kept: got %h expected 8877665544332211", r);
      end
   endtask

   task automatic test_contention();
      logic [1:0]  e;
      logic [63:0] r;
      host_we = 1'b1; host_addr = 9'd2; host_wdata = 64'h1111111111111111;
      memWrite = 1'b1; sizeSelect = 2'b00; address = 64'h15; writeData = 64'hFFFFFFFFFFFFFFAB;
      cyc();
      host_we = 1'b0; memWrite = 1'b0;
      req(1'b1, 1'b0, 2'b11, 64'h10, 64'h0, e, r);
      n_tests++;
      if (r !== 64'h1111AB1111111111) begin
         n_fail++; $display("FAIL merge_word2: got %h expected 1111ab1111111111", r);
      end
      host_write(9'd3, 64'hA5A5A5A5A5A5A5A5);
      host_we = 1'b1; host_addr = 9'd3; host_wdata = 64'h5A5A5A5A5A5A5A5A;
      memRead = 1'b1; sizeSelect = 2'b11; address = 64'h18;
      cyc();
      host_we = 1'b0; memRead = 1'b0;
      cyc();
      n_tests++;
      if (readData !== 64'hA5A5A5A5A5A5A5A5) begin
         n_fail++; $display("FAIL host_vs_load_old: got %h expected a5a5a5a5a5a5a5a5", readData);
      end
      req(1'b1, 1'b0, 2'b11, 64'h18, 64'h0, e, r);
      n_tests++;
      if (r !== 64'h5A5A5A5A5A5A5A5A) begin
         n_fail++; $display("FAIL host_vs_load_new: got %h expected 5a5a5a5a5a5a5a5a", r);
      end
   endtask

   task automatic test_reset_mid_scrub();
      logic [1:0]  e;
      logic [63:0] r;
      reset = 1'b0;
      repeat (2) cyc();
      n_tests++;
      if (readData !== 64'h0) begin n_fail++; $display("FAIL reset2_rdata: got %h expected 0", readData); end
      reset = 1'b1;
      repeat (200) cyc();
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_200: got %b expected 1", busy); end
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      measure_scrub("rescrub_len", 1'b0);
      for (int i = 0; i < 512; i++) begin
         req(1'b1, 1'b0, 2'b11, 64'(i) << 3, 64'h0, e, r);
         n_tests++;
         if (e !== 2'b00 || r !== 64'h0) begin
            n_fail++;
            $display("FAIL scrub_zero word %0d: got exc %b data %h expected 00 / 0", i, e, r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_host_load();
      test_back_to_back();
      test_faults();
      test_contention();
      test_reset_mid_scrub();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
